// File: rtl/keypad_encoder_pkg.sv
// Shared lock definitions: symbol width, default code length, encoder FSM
// states and the key-vector helpers used by the keypad encoder.
package keypad_encoder_pkg;

   localparam int SYM_W           = 2;
   localparam int LEN_W           = 3;
   localparam int MAX_LEN_DEFAULT = 4;

   typedef enum logic [1:0] {
      WAIT_RELEASE = 2'd0,
      IDLE         = 2'd1,
      SEND_CMP     = 2'd2
   } kp_state_e;

   function automatic logic one_hot4(input logic [3:0] v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

   function automatic logic [SYM_W-1:0] key_index(input logic [3:0] v);
      if (v[3])      return 2'd3;
      else if (v[2]) return 2'd2;
      else if (v[1]) return 2'd1;
      else           return 2'd0;
   endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser followed by a shared stability counter; the debounced
// vector only follows the synchronised buttons after they hold still.
module button_debouncer #(
   parameter int WIDTH           = 5,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic [WIDTH-1:0] raw,
   output logic [WIDTH-1:0] db,
   output logic             settled
);

   localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(DEBOUNCE_CYCLES - 2);

   logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;
   logic [WIDTH-1:0] db_q, db_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // db loads on the same edge the counter reaches its top value
   always_comb begin
      cnt_d = cnt_q;
      db_d  = db_q;
      if (sync2_q != prev_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX || cnt_q == CNT_PRE) begin
         cnt_d = CNT_MAX;
         db_d  = sync2_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
         cnt_q   <= '0;
         db_q    <= '0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         cnt_q   <= cnt_d;
         db_q    <= db_d;
      end
   end

   assign db      = db_q;
   assign settled = (cnt_q == CNT_MAX) && (sync1_q == sync2_q);

endmodule

// File: rtl/keypad_encoder.sv
// Keypad transmit end: debounced one-hot keys become 2-bit symbol strobes,
// enter (or a full code in auto mode) becomes a compare strobe.
module keypad_encoder
   import keypad_encoder_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int MAX_LEN         = MAX_LEN_DEFAULT,
   parameter int AUTO_COMPARE    = 1
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic [3:0]       key_raw,
   input  logic             enter_raw,
   output logic             input_value,
   output logic [SYM_W-1:0] bits,
   output logic             compare,
   output logic [LEN_W-1:0] pw_length,
   output logic             full
);

   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

   logic [4:0]       db;
   logic             settled;
   kp_state_e        state_q;
   logic             iv_q, cmp_q;
   logic [SYM_W-1:0] bits_q;
   logic [LEN_W-1:0] len_q;

   button_debouncer #(
      .WIDTH          (5),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clock  (clock),
      .resetn (resetn),
      .raw    ({enter_raw, key_raw}),
      .db     (db),
      .settled(settled)
   );

   // Leaving WAIT_RELEASE also needs a settled debouncer, so a button held
   // through reset is not mistaken for a fresh press once reset lifts.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= WAIT_RELEASE;
         iv_q    <= 1'b0;
         cmp_q   <= 1'b0;
         bits_q  <= '0;
         len_q   <= '0;
      end else begin
         iv_q  <= 1'b0;
         cmp_q <= 1'b0;
         case (state_q)
            WAIT_RELEASE: begin
               if (db == 5'd0 && settled) state_q <= IDLE;
            end
            IDLE: begin
               if (db[4]) begin
                  state_q <= SEND_CMP;
               end else if (one_hot4(db[3:0]) && len_q < LEN_MAX) begin
                  iv_q    <= 1'b1;
                  bits_q  <= key_index(db[3:0]);
                  len_q   <= len_q + 1'b1;
                  state_q <= (AUTO_COMPARE != 0 && (len_q + 1'b1) == LEN_MAX)
                             ? SEND_CMP : WAIT_RELEASE;
               end else if (db[3:0] != 4'd0) begin
                  state_q <= WAIT_RELEASE;
               end
            end
            SEND_CMP: begin
               cmp_q   <= 1'b1;
               len_q   <= '0;
               state_q <= WAIT_RELEASE;
            end
            default: state_q <= WAIT_RELEASE;
         endcase
      end
   end

   assign input_value = iv_q;
   assign bits        = bits_q;
   assign compare     = cmp_q;
   assign pw_length   = len_q;
   assign full        = (len_q == LEN_MAX);

endmodule

// File: tb/tb_keypad_encoder.sv
// Directed bench for keypad_encoder: one auto-compare instance and one
// manual-compare instance, each stepped cycle by cycle with strobe bookkeeping.
module tb_keypad_encoder;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic [3:0] key_raw = 4'd0, key_b = 4'd0;
   logic       enter_raw = 1'b0, enter_b = 1'b0;

   logic       input_value, compare, full;
   logic [1:0] bits;
   logic [2:0] pw_length;
   logic       iv_b, cmp_b, full_b;
   logic [1:0] bits_b;
   logic [2:0] pw_b;

   int n_chk = 0, n_pass = 0;
   int cyc, iv_n, iv_cyc, iv_pw, cmp_n, cmp_cyc, cmp_pw, both_n;
   int ivb_n, ivb_pw, cmpb_n, cmpb_pw;
   logic [1:0] iv_bits, ivb_bits;
   logic       iv_full;

   always #5 clock = ~clock;

   keypad_encoder #(.DEBOUNCE_CYCLES(4), .MAX_LEN(4), .AUTO_COMPARE(1)) dut (
      .clock(clock), .resetn(resetn), .key_raw(key_raw), .enter_raw(enter_raw),
      .input_value(input_value), .bits(bits), .compare(compare),
      .pw_length(pw_length), .full(full)
   );

   keypad_encoder #(.DEBOUNCE_CYCLES(4), .MAX_LEN(4), .AUTO_COMPARE(0)) dut_b (
      .clock(clock), .resetn(resetn), .key_raw(key_b), .enter_raw(enter_b),
      .input_value(iv_b), .bits(bits_b), .compare(cmp_b),
      .pw_length(pw_b), .full(full_b)
   );

   task automatic clr();
      cyc = 0; iv_n = 0; iv_cyc = -1; iv_pw = -1; iv_bits = 2'd0; iv_full = 1'b0;
      cmp_n = 0; cmp_cyc = -1; cmp_pw = -1; both_n = 0;
      ivb_n = 0; ivb_pw = -1; ivb_bits = 2'd0; cmpb_n = 0; cmpb_pw = -1;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      cyc++;
      if (input_value) begin
         iv_n++; iv_cyc = cyc; iv_bits = bits; iv_pw = int'(pw_length); iv_full = full;
      end
      if (compare) begin
         cmp_n++; cmp_cyc = cyc; cmp_pw = int'(pw_length);
      end
      if (input_value && compare) both_n++;
      if (iv_b) begin
         ivb_n++; ivb_bits = bits_b; ivb_pw = int'(pw_b);
      end
      if (cmp_b) begin
         cmpb_n++; cmpb_pw = int'(pw_b);
      end
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      step(); step();
      resetn = 1'b1;
      repeat (8) step();
      clr();
   endtask

   task automatic test_reset();
      clr();
      resetn = 1'b0;
      step(); step();
      n_chk++; if ({input_value, bits, compare, pw_length, full} !== 8'd0)
         $display("FAIL reset_outs: got %b want 0", {input_value, bits, compare, pw_length, full});
      else n_pass++;
      n_chk++; if ({iv_b, bits_b, cmp_b, pw_b, full_b} !== 8'd0)
         $display("FAIL reset_outs_b: got %b want 0", {iv_b, bits_b, cmp_b, pw_b, full_b});
      else n_pass++;
      resetn = 1'b1;
      repeat (10) step();
      n_chk++; if (iv_n + cmp_n !== 0)
         $display("FAIL reset_idle_strobes: got %0d want 0", iv_n + cmp_n);
      else n_pass++;
   endtask

   task automatic test_single_key();
      do_reset();
      key_raw = 4'b0100;
      repeat (6) step();
      n_chk++; if (iv_n !== 0) $display("FAIL single_early: got %0d strobes want 0", iv_n);
      else n_pass++;
      repeat (25) step();
      n_chk++; if (iv_n !== 1) $display("FAIL single_count: got %0d want 1", iv_n);
      else n_pass++;
      n_chk++; if (iv_cyc !== 7) $display("FAIL single_latency: got %0d want 7", iv_cyc);
      else n_pass++;
      n_chk++; if (iv_bits !== 2'd2) $display("FAIL single_bits: got %0d want 2", iv_bits);
      else n_pass++;
      n_chk++; if (iv_pw !== 1) $display("FAIL single_len: got %0d want 1", iv_pw);
      else n_pass++;
      key_raw = 4'd0;
      repeat (10) step();
   endtask

   task automatic test_sequence();
      int syms[4] = '{3, 0, 1, 2};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         clr();
         key_raw = 4'b0001 << syms[i];
         repeat (10) step();
         key_raw = 4'd0;
         repeat (10) step();
         n_chk++; if (iv_n !== 1 || iv_bits !== 2'(syms[i]) || iv_pw !== i + 1)
            $display("FAIL seq_sym%0d: got n=%0d bits=%0d len=%0d want n=1 bits=%0d len=%0d",
                     i, iv_n, iv_bits, iv_pw, syms[i], i + 1);
         else n_pass++;
         if (i < 3) begin
            n_chk++; if (cmp_n !== 0) $display("FAIL seq_early_cmp%0d: got %0d want 0", i, cmp_n);
            else n_pass++;
         end else begin
            n_chk++; if (cmp_n !== 1 || cmp_cyc !== iv_cyc + 1 || cmp_pw !== 0)
               $display("FAIL seq_auto_cmp: got n=%0d at %0d len=%0d want n=1 at %0d len=0",
                        cmp_n, cmp_cyc, cmp_pw, iv_cyc + 1);
            else n_pass++;
            n_chk++; if (iv_full !== 1'b1 || both_n !== 0)
               $display("FAIL seq_full_overlap: got full=%0d both=%0d want 1 0", iv_full, both_n);
            else n_pass++;
         end
      end
   endtask

   task automatic test_no_auto();
      do_reset();
      for (int i = 0; i < 2; i++) begin
         clr();
         key_b = 4'b0010;
         repeat (10) step();
         key_b = 4'd0;
         repeat (10) step();
         n_chk++; if (ivb_n !== 1 || ivb_bits !== 2'd1 || ivb_pw !== i + 1 || cmpb_n !== 0)
            $display("FAIL noauto_key%0d: got n=%0d bits=%0d len=%0d cmp=%0d want 1 1 %0d 0",
                     i, ivb_n, ivb_bits, ivb_pw, cmpb_n, i + 1);
         else n_pass++;
      end
      clr();
      enter_b = 1'b1;
      repeat (10) step();
      enter_b = 1'b0;
      repeat (10) step();
      n_chk++; if (ivb_n !== 0 || cmpb_n !== 1 || cmpb_pw !== 0 || pw_b !== 3'd0)
         $display("FAIL noauto_enter: got iv=%0d cmp=%0d len=%0d want 0 1 0", ivb_n, cmpb_n, pw_b);
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         key_b = 4'b0001;
         repeat (10) step();
         key_b = 4'd0;
         repeat (10) step();
      end
      n_chk++; if (pw_b !== 3'd4 || full_b !== 1'b1)
         $display("FAIL noauto_full: got len=%0d full=%0d want 4 1", pw_b, full_b);
      else n_pass++;
      clr();
      key_b = 4'b1000;
      repeat (10) step();
      key_b = 4'd0;
      repeat (10) step();
      n_chk++; if (ivb_n !== 0 || pw_b !== 3'd4)
         $display("FAIL noauto_overflow: got iv=%0d len=%0d want 0 4", ivb_n, pw_b);
      else n_pass++;
      enter_b = 1'b1;
      repeat (10) step();
      enter_b = 1'b0;
      repeat (10) step();
      n_chk++; if (cmpb_n !== 1 || full_b !== 1'b0 || pw_b !== 3'd0)
         $display("FAIL noauto_full_cmp: got cmp=%0d full=%0d len=%0d want 1 0 0", cmpb_n, full_b, pw_b);
      else n_pass++;
   endtask

   task automatic test_bounce();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         key_raw[1] = ~key_raw[1];
         step(); step();
      end
      n_chk++; if (iv_n !== 0) $display("FAIL bounce_during: got %0d strobes want 0", iv_n);
      else n_pass++;
      clr();
      key_raw[1] = 1'b1;
      repeat (20) step();
      n_chk++; if (iv_n !== 1 || iv_cyc !== 7 || iv_bits !== 2'd1)
         $display("FAIL bounce_accept: got n=%0d at %0d bits=%0d want 1 at 7 bits=1", iv_n, iv_cyc, iv_bits);
      else n_pass++;
      key_raw = 4'd0;
      repeat (10) step();
   endtask

   task automatic test_chord();
      do_reset();
      key_raw = 4'b1000;
      repeat (10) step();
      key_raw = 4'd0;
      repeat (10) step();
      clr();
      key_raw = 4'b0011;
      repeat (12) step();
      key_raw = 4'd0;
      repeat (10) step();
      n_chk++; if (iv_n !== 0 || cmp_n !== 0 || bits !== 2'd3 || pw_length !== 3'd1)
         $display("FAIL chord_reject: got iv=%0d cmp=%0d bits=%0d len=%0d want 0 0 3 1",
                  iv_n, cmp_n, bits, pw_length);
      else n_pass++;
      clr();
      key_raw   = 4'b0100;
      enter_raw = 1'b1;
      repeat (12) step();
      key_raw   = 4'd0;
      enter_raw = 1'b0;
      repeat (10) step();
      n_chk++; if (iv_n !== 0 || cmp_n !== 1 || cmp_cyc !== 8)
         $display("FAIL enter_priority: got iv=%0d cmp=%0d at %0d want 0 1 at 8", iv_n, cmp_n, cmp_cyc);
      else n_pass++;
      n_chk++; if (bits !== 2'd3 || pw_length !== 3'd0)
         $display("FAIL enter_state: got bits=%0d len=%0d want 3 0", bits, pw_length);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 2; i++) begin
         key_raw = 4'b0001 << i;
         repeat (10) step();
         key_raw = 4'd0;
         repeat (10) step();
      end
      n_chk++; if (pw_length !== 3'd2) $display("FAIL mid_prelen: got %0d want 2", pw_length);
      else n_pass++;
      clr();
      key_raw = 4'b1000;
      repeat (6) step();
      resetn = 1'b0;
      #1;
      n_chk++; if (pw_length !== 3'd0 || input_value !== 1'b0)
         $display("FAIL mid_async: got len=%0d iv=%0d want 0 0", pw_length, input_value);
      else n_pass++;
      step();
      resetn = 1'b1;
      repeat (20) step();
      n_chk++; if (iv_n !== 0 || cmp_n !== 0 || pw_length !== 3'd0)
         $display("FAIL mid_held_ignored: got iv=%0d cmp=%0d len=%0d want 0 0 0", iv_n, cmp_n, pw_length);
      else n_pass++;
      key_raw = 4'd0;
      repeat (10) step();
      clr();
      key_raw = 4'b0100;
      repeat (10) step();
      key_raw = 4'd0;
      repeat (10) step();
      n_chk++; if (iv_n !== 1 || iv_bits !== 2'd2 || iv_pw !== 1)
         $display("FAIL mid_recover: got n=%0d bits=%0d len=%0d want 1 2 1", iv_n, iv_bits, iv_pw);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single_key();
      test_sequence();
      test_no_auto();
      test_bounce();
      test_chord();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
